// File: rtl/multicycle_controller_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_controller_pkg
//  Description : Shared encodings for the multicycle RISC-V controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package multicycle_controller_pkg;

    localparam logic [3:0] c_S_FETCH    = 4'd0;
    localparam logic [3:0] c_S_DECODE   = 4'd1;
    localparam logic [3:0] c_S_MEMADR   = 4'd2;
    localparam logic [3:0] c_S_MEMREAD  = 4'd3;
    localparam logic [3:0] c_S_MEMWB    = 4'd4;
    localparam logic [3:0] c_S_MEMWRITE = 4'd5;
    localparam logic [3:0] c_S_EXECUTER = 4'd6;
    localparam logic [3:0] c_S_EXECUTEI = 4'd7;
    localparam logic [3:0] c_S_ALUWB    = 4'd8;
    localparam logic [3:0] c_S_BEQ      = 4'd9;
    localparam logic [3:0] c_S_JAL      = 4'd10;

    localparam logic [6:0] c_OP_LW    = 7'b0000011;
    localparam logic [6:0] c_OP_SW    = 7'b0100011;
    localparam logic [6:0] c_OP_RTYPE = 7'b0110011;
    localparam logic [6:0] c_OP_ITYPE = 7'b0010011;
    localparam logic [6:0] c_OP_JAL   = 7'b1101111;
    localparam logic [6:0] c_OP_BEQ   = 7'b1100011;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_t;

    localparam logic [2:0] c_ALUC_ADD = 3'b000;
    localparam logic [2:0] c_ALUC_SUB = 3'b001;
    localparam logic [2:0] c_ALUC_AND = 3'b010;
    localparam logic [2:0] c_ALUC_OR  = 3'b011;
    localparam logic [2:0] c_ALUC_SLT = 3'b101;

    localparam logic [1:0] c_IMM_I = 2'b00;
    localparam logic [1:0] c_IMM_S = 2'b01;
    localparam logic [1:0] c_IMM_B = 2'b10;
    localparam logic [1:0] c_IMM_J = 2'b11;

    function automatic logic [1:0] imm_src_of(input logic [6:0] op);
        case (op)
            c_OP_SW:  imm_src_of = c_IMM_S;
            c_OP_BEQ: imm_src_of = c_IMM_B;
            c_OP_JAL: imm_src_of = c_IMM_J;
            default:  imm_src_of = c_IMM_I;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/multicycle_controller_alu_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : alu_decoder
//  Description : Maps ALUOp and instruction function fields to ALUControl.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_decoder
    import multicycle_controller_pkg::*;
(
    input  alu_op_t    i_alu_op,
    input  logic [2:0] i_funct3,
    input  logic       i_op5,
    input  logic       i_funct7b5,
    output logic [2:0] o_alu_control
);

    always_comb begin
        o_alu_control = c_ALUC_ADD;
        case (i_alu_op)
            ALUOP_ADD: o_alu_control = c_ALUC_ADD;
            ALUOP_SUB: o_alu_control = c_ALUC_SUB;
            ALUOP_FUNCT: begin
                case (i_funct3)
                    // funct7b5 selects sub only for R-type; addi keeps bit 30 as immediate
                    3'b000:  o_alu_control = (i_op5 & i_funct7b5) ? c_ALUC_SUB : c_ALUC_ADD;
                    3'b010:  o_alu_control = c_ALUC_SLT;
                    3'b110:  o_alu_control = c_ALUC_OR;
                    3'b111:  o_alu_control = c_ALUC_AND;
                    default: o_alu_control = c_ALUC_ADD;
                endcase
            end
            default: o_alu_control = c_ALUC_ADD;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_controller
//  Description : Moore control FSM for a multicycle RV32 subset datapath.
//  Revision    : 1.0 - initial release
// ============================================================================
module multicycle_controller
    import multicycle_controller_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUControl,
    output logic [1:0] ImmSrc,
    output logic       RegWrite
);

    logic [3:0] r_state;
    logic [3:0] w_next;
    logic       w_pc_update;
    logic       w_branch;
    alu_op_t    w_alu_op;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = c_S_FETCH;
        case (r_state)
            c_S_FETCH: w_next = c_S_DECODE;
            c_S_DECODE: begin
                case (op)
                    c_OP_LW, c_OP_SW: w_next = c_S_MEMADR;
                    c_OP_RTYPE:       w_next = c_S_EXECUTER;
                    c_OP_ITYPE:       w_next = c_S_EXECUTEI;
                    c_OP_JAL:         w_next = c_S_JAL;
                    c_OP_BEQ:         w_next = c_S_BEQ;
                    default:          w_next = c_S_FETCH;
                endcase
            end
            c_S_MEMADR: begin
                if (op == c_OP_LW) begin
                    w_next = c_S_MEMREAD;
                end else if (op == c_OP_SW) begin
                    w_next = c_S_MEMWRITE;
                end else begin
                    w_next = c_S_FETCH;
                end
            end
            c_S_MEMREAD:  w_next = c_S_MEMWB;
            c_S_EXECUTER: w_next = c_S_ALUWB;
            c_S_EXECUTEI: w_next = c_S_ALUWB;
            c_S_JAL:      w_next = c_S_ALUWB;
            default:      w_next = c_S_FETCH;
        endcase
    end

    always_comb begin
        w_pc_update = 1'b0;
        w_branch    = 1'b0;
        w_alu_op    = ALUOP_ADD;
        AdrSrc      = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        ResultSrc   = 2'b00;
        ALUSrcA     = 2'b00;
        ALUSrcB     = 2'b00;
        RegWrite    = 1'b0;
        ImmSrc      = imm_src_of(op);
        case (r_state)
            c_S_FETCH: begin
                IRWrite     = 1'b1;
                ALUSrcB     = 2'b10;
                ResultSrc   = 2'b10;
                w_pc_update = 1'b1;
            end
            c_S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
            end
            c_S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            c_S_MEMREAD: begin
                AdrSrc = 1'b1;
            end
            c_S_MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
            end
            c_S_MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
            end
            c_S_EXECUTER: begin
                ALUSrcA  = 2'b10;
                w_alu_op = ALUOP_FUNCT;
            end
            c_S_EXECUTEI: begin
                ALUSrcA  = 2'b10;
                ALUSrcB  = 2'b01;
                w_alu_op = ALUOP_FUNCT;
            end
            c_S_ALUWB: begin
                RegWrite = 1'b1;
            end
            c_S_JAL: begin
                ALUSrcA     = 2'b01;
                ALUSrcB     = 2'b10;
                w_pc_update = 1'b1;
            end
            c_S_BEQ: begin
                ALUSrcA  = 2'b10;
                w_alu_op = ALUOP_SUB;
                w_branch = 1'b1;
            end
            default: begin
                w_pc_update = 1'b0;
            end
        endcase
        // Reset silences every output, not only the write enables
        if (reset) begin
            w_pc_update = 1'b0;
            w_branch    = 1'b0;
            w_alu_op    = ALUOP_ADD;
            AdrSrc      = 1'b0;
            MemWrite    = 1'b0;
            IRWrite     = 1'b0;
            ResultSrc   = 2'b00;
            ALUSrcA     = 2'b00;
            ALUSrcB     = 2'b00;
            RegWrite    = 1'b0;
            ImmSrc      = 2'b00;
        end
    end

    assign PCWrite = w_pc_update | (w_branch & Zero);

    alu_decoder u_alu_decoder (
        .i_alu_op      (w_alu_op),
        .i_funct3      (funct3),
        .i_op5         (op[5]),
        .i_funct7b5    (funct7b5),
        .o_alu_control (ALUControl)
    );

endmodule
`default_nettype wire

// File: tb/tb_multicycle_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multicycle_controller
//  Description : Random instruction stream checked against a cycle-table model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;

    int n_checks = 0;
    int n_fail   = 0;

    // Steps an instruction walks through, named by what the datapath does
    localparam int ST_FETCH = 0, ST_DECODE = 1, ST_MEMADR = 2, ST_MEMREAD = 3,
                   ST_MEMWB = 4, ST_MEMWRITE = 5, ST_EXECR = 6, ST_EXECI = 7,
                   ST_ALUWB = 8, ST_BEQ = 9, ST_JAL = 10;

    int seq[$];

    multicycle_controller dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .Zero       (Zero),
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ALUControl (ALUControl),
        .ImmSrc     (ImmSrc),
        .RegWrite   (RegWrite)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %04h expected %04h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic void build_seq(input logic [6:0] o);
        case (o)
            7'b0000011: seq = '{ST_FETCH, ST_DECODE, ST_MEMADR, ST_MEMREAD, ST_MEMWB};
            7'b0100011: seq = '{ST_FETCH, ST_DECODE, ST_MEMADR, ST_MEMWRITE};
            7'b0110011: seq = '{ST_FETCH, ST_DECODE, ST_EXECR, ST_ALUWB};
            7'b0010011: seq = '{ST_FETCH, ST_DECODE, ST_EXECI, ST_ALUWB};
            7'b1101111: seq = '{ST_FETCH, ST_DECODE, ST_JAL, ST_ALUWB};
            7'b1100011: seq = '{ST_FETCH, ST_DECODE, ST_BEQ};
            default:    seq = '{ST_FETCH, ST_DECODE};
        endcase
    endfunction

    // Expected output vector:
    // {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegWrite}
    function automatic logic [15:0] model(input int st, input logic [6:0] o, input logic [2:0] f3,
                                          input logic f7, input logic z, input logic rst);
        logic pcw, adr, mw, irw, rw;
        logic [1:0] res, sa, sb, imm;
        logic [2:0] aluc;
        string kind;
        pcw = 0; adr = 0; mw = 0; irw = 0; rw = 0;
        res = 0; sa = 0; sb = 0; aluc = 3'b000; kind = "add";
        if (rst) return 16'h0000;
        imm = (o == 7'b0100011) ? 2'b01 : (o == 7'b1100011) ? 2'b10 :
              (o == 7'b1101111) ? 2'b11 : 2'b00;
        case (st)
            ST_FETCH:    begin irw = 1; sb = 2'b10; res = 2'b10; pcw = 1; end
            ST_DECODE:   begin sa = 2'b01; sb = 2'b01; end
            ST_MEMADR:   begin sa = 2'b10; sb = 2'b01; end
            ST_MEMREAD:  begin adr = 1; end
            ST_MEMWB:    begin res = 2'b01; rw = 1; end
            ST_MEMWRITE: begin adr = 1; mw = 1; end
            ST_EXECR:    begin sa = 2'b10; kind = "funct"; end
            ST_EXECI:    begin sa = 2'b10; sb = 2'b01; kind = "funct"; end
            ST_ALUWB:    begin rw = 1; end
            ST_JAL:      begin sa = 2'b01; sb = 2'b10; pcw = 1; end
            ST_BEQ:      begin sa = 2'b10; kind = "sub"; pcw = z; end
            default:     ;
        endcase
        if (kind == "sub") aluc = 3'b001;
        else if (kind == "funct") begin
            if (f3 == 3'b000)      aluc = (o[5] && f7) ? 3'b001 : 3'b000;
            else if (f3 == 3'b010) aluc = 3'b101;
            else if (f3 == 3'b110) aluc = 3'b011;
            else if (f3 == 3'b111) aluc = 3'b010;
        end
        return {pcw, adr, mw, irw, res, sa, sb, aluc, imm, rw};
    endfunction

    function automatic logic [15:0] observed();
        return {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
                ALUControl, ImmSrc, RegWrite};
    endfunction

    // zmode: 0/1 force Zero, 2 randomise per cycle; rst_at: step index to pulse reset, -1 none
    task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                             input int zmode, input int rst_at);
        build_seq(o);
        for (int i = 0; i < seq.size(); i++) begin
            op       = o;
            funct3   = f3;
            funct7b5 = f7;
            Zero     = (zmode == 2) ? 1'($urandom) : 1'(zmode);
            reset    = (i == rst_at);
            @(negedge clk);
            check_eq($sformatf("op%07b step%0d%s", o, seq[i], reset ? " rst" : ""),
                     observed(), model(seq[i], o, f3, f7, Zero, reset));
            @(posedge clk);
            #1;
            if (i == rst_at) break;
        end
        reset = 1'b0;
    endtask

    function automatic logic [6:0] pick_op();
        logic [6:0] r;
        case ($urandom_range(0, 6))
            0: return 7'b0000011;
            1: return 7'b0100011;
            2: return 7'b0110011;
            3: return 7'b0010011;
            4: return 7'b1101111;
            5: return 7'b1100011;
            default: begin
                r = 7'($urandom);
                if (r == 7'b0000011 || r == 7'b0100011 || r == 7'b0110011 ||
                    r == 7'b0010011 || r == 7'b1101111 || r == 7'b1100011)
                    r = 7'b1111111;
                return r;
            end
        endcase
    endfunction

    initial begin
        reset = 1'b1; op = 7'b0000011; funct3 = 3'b000; funct7b5 = 1'b0; Zero = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("reset state", observed(), 16'h0000);
        @(posedge clk); #1;
        reset = 1'b0;

        run_instr(7'b0000011, 3'b010, 1'b0, 2, 3);    // reset during MEMREAD
        run_instr(7'b0000011, 3'b010, 1'b0, 2, -1);
        run_instr(7'b0100011, 3'b010, 1'b0, 2, -1);
        run_instr(7'b0110011, 3'b000, 1'b1, 2, -1);
        run_instr(7'b0010011, 3'b000, 1'b1, 2, -1);
        run_instr(7'b1100011, 3'b000, 1'b0, 1, -1);
        run_instr(7'b1100011, 3'b000, 1'b0, 0, -1);
        run_instr(7'b1101111, 3'b000, 1'b0, 2, -1);
        run_instr(7'b1111111, 3'b000, 1'b0, 2, -1);
        run_instr(7'b0110011, 3'b110, 1'b0, 2, 1);    // reset during DECODE

        for (int n = 0; n < 400; n++) begin
            logic [6:0] o;
            int ra;
            o = pick_op();
            build_seq(o);
            ra = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, seq.size() - 1)) : -1;
            run_instr(o, 3'($urandom), 1'($urandom), 2, ra);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
